enigma_resp_tx: RTL and testbench
=================================

Name: enigma_resp_tx

Overview:
Response transmitter for the Enigma I UART command interface. It accepts one message request per handshake from the command/cipher core: the banner, OK, ERR, or a single cipher character. It expands the request into its byte sequence and serialises each byte onto uart_tx as 8N1, LSB first. It is the transmit-side counterpart of the command receiver and sits between the core and the uart_tx pin of enigma_top.

Parameters:
CLKS_PER_BIT, 104, clock cycles per UART bit (12 MHz / 115200).

Ports:
clk  input  1  system clock (12 MHz)
rst_n  input  1  synchronous active-low reset, sampled on rising clk
msg_valid  input  1  request strobe from core
msg_id  input  2  request type: 0=BANNER, 1=OK, 2=ERR, 3=CHAR
msg_char  input  8  byte to send when msg_id=CHAR; ignored otherwise
msg_ready  output  1  high when a new request can be accepted
busy  output  1  high from acceptance until the last stop bit ends
uart_tx  output  1  serial line, idle high

Behaviour:
- Reset: clk is the single clock; rst_n is synchronous and active-low. While rst_n is low, on each rising clk edge:
  - uart_tx=1, msg_ready=0, busy=0.
  - Byte index, bit counter, baud counter and group counter all go to 0.
  - FSM goes to IDLE.
  - msg_ready rises on the first edge with rst_n high.
- Reset asserted mid-frame: the in-flight message is dropped. uart_tx is high on the next edge. No partial byte is resumed.
- Handshake: a request is accepted on an edge where msg_valid && msg_ready. On that edge msg_id and msg_char are latched, msg_ready drops and busy rises. msg_valid while msg_ready=0 is ignored; nothing is queued.
- Message contents, sent in order:
  - BANNER: "ENIGMA I READY" followed by 0x0D 0x0A (16 bytes).
  - OK: 0x4F 0x4B 0x0D 0x0A.
  - ERR: 0x45 0x52 0x52 0x0D 0x0A.
  - CHAR: msg_char (1 byte).
  - Bytes come from a constant table indexed by {msg_id, byte_idx}.
- FSM states:
  - IDLE: msg_ready=1. On accept go to LOAD.
  - LOAD: present the current table byte to the serialiser with a start pulse, then go to SEND.
  - SEND: wait for serialiser done. If more bytes remain, increment byte_idx and go to LOAD; otherwise go to IDLE.
- Latency: the uart_tx falling edge (start bit) occurs on the 2nd rising edge after the accept edge.
- Consecutive bytes within one message are back-to-back. The start bit of byte k+1 follows the stop bit of byte k with at most 2 cycles of extra idle.
- Serialiser frame:
  - 1 start bit (0), 8 data bits LSB first, 1 stop bit (1).
  - Each bit is held exactly CLKS_PER_BIT cycles.
  - done pulses 1 cycle at the end of the stop bit.
- Counter wrap: the baud counter counts 0..CLKS_PER_BIT-1 and then wraps to 0. The bit counter counts 0..9.
- End of message: busy falls on the same edge msg_ready rises, which is the edge after the last done pulse.
- msg_char latching: it is captured only at acceptance, so later changes while busy have no effect.

Optional Feature:
- Macro: RESP_GROUP5_EN.
- When defined:
  - A 3-bit group counter counts consecutive CHAR messages.
  - After every 5th CHAR, a 0x20 space is appended within the same message (busy covers both bytes) and the counter returns to 0.
  - Any BANNER, OK or ERR acceptance, or reset, clears the counter.
- When undefined: the counter logic is absent and CHAR always sends exactly one byte.

Decomposition:
- Shared package enigma_pkg holds:
  - MSG_BANNER/MSG_OK/MSG_ERR/MSG_CHAR encodings.
  - Message lengths (16/4/5/1).
  - ASCII constants CR=0x0D, LF=0x0A, SP=0x20.
  - Default CLKS_PER_BIT=104.
- One sub-module, uart_tx_serializer: clk, rst_n, start, data[7:0], tx, done. It contains the baud and bit counters.
- The message table and FSM stay in enigma_resp_tx.

Test Plan:
- Reset: hold rst_n low 5 cycles, release -> uart_tx=1 and busy=0 throughout; msg_ready=1 one edge after release.
- OK request (msg_id=1) -> background receiver gets 0x4F 0x4B 0x0D 0x0A. busy high for 4×1040 cycles +≤8. Start bit is low for exactly 104 cycles.
- BANNER request -> 16 bytes "ENIGMA I READY\r\n". The ERR request that follows gives 0x45 0x52 0x52 0x0D 0x0A.
- CHAR 'U' (0x55) accepted, then msg_char changed to 0x00 and msg_valid pulsed while busy -> exactly one byte 0x55 received; the second request is ignored.
- Reset asserted 300 cycles into an ERR message -> uart_tx high next edge. A following OK request is received cleanly as 0x4F 0x4B 0x0D 0x0A.
- With RESP_GROUP5_EN: CHAR×7 "BDZGOAA" -> received "BDZGO AA". A following OK resets grouping, so CHAR×5 afterwards again ends in 0x20.

Source files
------------

// File: rtl/enigma_pkg.sv
`default_nettype none
// ============================================================================
// Module      : enigma_pkg
// Description : Shared encodings and constants for the Enigma I UART command
//               interface: request types, message lengths, ASCII control
//               characters and the default UART bit period.
// Revision    : 1.0 - initial release
// ============================================================================
package enigma_pkg;

  // Request type encodings on msg_id
  localparam logic [1:0] MSG_BANNER = 2'd0;
  localparam logic [1:0] MSG_OK     = 2'd1;
  localparam logic [1:0] MSG_ERR    = 2'd2;
  localparam logic [1:0] MSG_CHAR   = 2'd3;

  // Message lengths in bytes (5 bits so that 16 fits)
  localparam logic [4:0] LEN_BANNER = 5'd16;
  localparam logic [4:0] LEN_OK     = 5'd4;
  localparam logic [4:0] LEN_ERR    = 5'd5;
  localparam logic [4:0] LEN_CHAR   = 5'd1;

  // ASCII constants
  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_LF = 8'h0A;
  localparam logic [7:0] ASCII_SP = 8'h20;

  // 12 MHz / 115200 baud
  localparam int CLKS_PER_BIT_DEFAULT = 104;

  // Response transmitter states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_SEND = 2'd2
  } tx_state_t;

  // Base length of a message, before any optional trailing space
  function automatic logic [4:0] msg_len(input logic [1:0] id);
    case (id)
      MSG_BANNER: msg_len = LEN_BANNER;
      MSG_OK:     msg_len = LEN_OK;
      MSG_ERR:    msg_len = LEN_ERR;
      default:    msg_len = LEN_CHAR;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_tx_serializer.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_serializer
// Description : 8N1 UART byte transmitter, LSB first. A start pulse while idle
//               launches one frame; done is high during the final clock of
//               the stop bit so the caller can chain the next byte with
//               minimal idle time.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_serializer
  import enigma_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] data,
  output logic       tx,
  output logic       done
);

  localparam int              BAUD_W    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [3:0]      BIT_STOP  = 4'd9;

  logic              r_active;
  logic [BAUD_W-1:0] r_baud;
  logic [3:0]        r_bit;     // 0 = start, 1..8 = data, 9 = stop
  logic [7:0]        r_shift;   // remaining data bits, refilled with 1s
  logic              r_tx;

  // Frame sequencer: baud counter paces bits, shift register supplies data
  // and naturally yields the stop-bit 1 after the eighth shift.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_active <= 1'b0;
      r_baud   <= '0;
      r_bit    <= '0;
      r_shift  <= '0;
      r_tx     <= 1'b1;
    end else if (!r_active) begin
      if (start) begin
        r_active <= 1'b1;
        r_baud   <= '0;
        r_bit    <= '0;
        r_shift  <= data;
        r_tx     <= 1'b0;
      end
    end else if (r_baud == BAUD_LAST) begin
      r_baud <= '0;
      if (r_bit == BIT_STOP) begin
        r_active <= 1'b0;
        r_bit    <= '0;
      end else begin
        r_bit   <= r_bit + 4'd1;
        r_tx    <= r_shift[0];
        r_shift <= {1'b1, r_shift[7:1]};
      end
    end else begin
      r_baud <= r_baud + 1'b1;
    end
  end

  assign tx   = r_tx;
  assign done = r_active && (r_bit == BIT_STOP) && (r_baud == BAUD_LAST);

endmodule
`default_nettype wire

// File: rtl/enigma_resp_tx.sv
`default_nettype none
// ============================================================================
// Module      : enigma_resp_tx
// Description : Response transmitter for the Enigma I UART command interface.
//               Accepts one request (BANNER / OK / ERR / CHAR), expands it
//               from a constant byte table and serialises it as 8N1.
//               Optional macro RESP_GROUP5_EN appends a space after every
//               fifth consecutive CHAR message.
// Revision    : 1.0 - initial release
// ============================================================================
module enigma_resp_tx
  import enigma_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       msg_valid,
  input  logic [1:0] msg_id,
  input  logic [7:0] msg_char,
  output logic       msg_ready,
  output logic       busy,
  output logic       uart_tx
);

  tx_state_t  r_state;
  tx_state_t  w_state_nxt;
  logic       r_up;         // low for the reset cycles, keeps msg_ready low
  logic [1:0] r_id;
  logic [7:0] r_char;
  logic [3:0] r_byte_idx;
  logic       r_start;
  logic [7:0] r_byte;
  logic       w_accept;
  logic       w_done;
  logic       w_last;
  logic [4:0] w_len;

  // Constant message table addressed by {msg_id, byte_idx}
  function automatic logic [7:0] table_byte(input logic [5:0] addr, input logic [7:0] ch);
    case (addr)
      6'h00: table_byte = "E";
      6'h01: table_byte = "N";
      6'h02: table_byte = "I";
      6'h03: table_byte = "G";
      6'h04: table_byte = "M";
      6'h05: table_byte = "A";
      6'h06: table_byte = " ";
      6'h07: table_byte = "I";
      6'h08: table_byte = " ";
      6'h09: table_byte = "R";
      6'h0A: table_byte = "E";
      6'h0B: table_byte = "A";
      6'h0C: table_byte = "D";
      6'h0D: table_byte = "Y";
      6'h0E: table_byte = ASCII_CR;
      6'h0F: table_byte = ASCII_LF;
      6'h10: table_byte = "O";
      6'h11: table_byte = "K";
      6'h12: table_byte = ASCII_CR;
      6'h13: table_byte = ASCII_LF;
      6'h20: table_byte = "E";
      6'h21: table_byte = "R";
      6'h22: table_byte = "R";
      6'h23: table_byte = ASCII_CR;
      6'h24: table_byte = ASCII_LF;
      6'h30: table_byte = ch;
      6'h31: table_byte = ASCII_SP;
      default: table_byte = 8'hFF;
    endcase
  endfunction

  assign w_accept  = msg_valid && msg_ready;
  assign msg_ready = r_up && (r_state == ST_IDLE);
  assign busy      = (r_state != ST_IDLE);
  assign w_last    = ({1'b0, r_byte_idx} == (w_len - 5'd1));

`ifdef RESP_GROUP5_EN
  logic [2:0] r_group;   // CHAR messages since the last appended space
  logic       r_append;  // current CHAR message carries a trailing space

  // Group counter: every fifth consecutive CHAR gets a trailing space
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_group  <= '0;
      r_append <= 1'b0;
    end else if (w_accept) begin
      if (msg_id == MSG_CHAR) begin
        if (r_group == 3'd4) begin
          r_group  <= '0;
          r_append <= 1'b1;
        end else begin
          r_group  <= r_group + 3'd1;
          r_append <= 1'b0;
        end
      end else begin
        r_group  <= '0;
        r_append <= 1'b0;
      end
    end
  end

  assign w_len = ((r_id == MSG_CHAR) && r_append) ? 5'd2 : msg_len(r_id);
`else
  assign w_len = msg_len(r_id);
`endif

  // FSM state register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_accept) w_state_nxt = ST_LOAD;
      ST_LOAD: w_state_nxt = ST_SEND;
      ST_SEND: if (w_done) w_state_nxt = w_last ? ST_IDLE : ST_LOAD;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Request latch, byte index and registered byte/start handoff to serialiser
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_up       <= 1'b0;
      r_id       <= MSG_BANNER;
      r_char     <= '0;
      r_byte_idx <= '0;
      r_start    <= 1'b0;
      r_byte     <= '0;
    end else begin
      r_up    <= 1'b1;
      r_start <= (r_state == ST_LOAD);
      if (r_state == ST_LOAD) begin
        r_byte <= table_byte({r_id, r_byte_idx}, r_char);
      end
      if (w_accept) begin
        r_id       <= msg_id;
        r_char     <= msg_char;
        r_byte_idx <= '0;
      end else if ((r_state == ST_SEND) && w_done && !w_last) begin
        r_byte_idx <= r_byte_idx + 4'd1;
      end
    end
  end

  uart_tx_serializer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_ser (
    .clk   (clk),
    .rst_n (rst_n),
    .start (r_start),
    .data  (r_byte),
    .tx    (uart_tx),
    .done  (w_done)
  );

endmodule
`default_nettype wire

// File: tb/tb_enigma_resp_tx.sv
`default_nettype none
// ============================================================================
// Module      : tb_enigma_resp_tx
// Description : Self-checking bench for enigma_resp_tx. A message-level model
//               predicts the byte stream; a line receiver decodes uart_tx and
//               compares every byte, plus handshake/timing invariants.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_enigma_resp_tx;

  localparam int CPB = 104;
  localparam int FRAME = 10 * CPB;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       msg_valid = 1'b0;
  logic [1:0] msg_id = 2'd0;
  logic [7:0] msg_char = 8'h00;
  logic       msg_ready;
  logic       busy;
  logic       uart_tx;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic rst_q = 1'b0;

  logic [7:0] exp_q[$];
  logic [7:0] rx_log[$];

  always #5 clk = ~clk;

  enigma_resp_tx #(.CLKS_PER_BIT(CPB)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .msg_valid (msg_valid),
    .msg_id    (msg_id),
    .msg_char  (msg_char),
    .msg_ready (msg_ready),
    .busy      (busy),
    .uart_tx   (uart_tx)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- message-level model ----------------
  function automatic string model_text(input logic [1:0] id);
    case (id)
      2'd0:    return "ENIGMA I READY";
      2'd1:    return "OK";
      2'd2:    return "ERR";
      default: return "";
    endcase
  endfunction

  function automatic int model_len(input logic [1:0] id);
    string s;
    s = model_text(id);
    return (id == 2'd3) ? 1 : s.len() + 2;
  endfunction

  function automatic logic [7:0] model_byte(input logic [1:0] id, input logic [7:0] ch, input int i);
    string s;
    s = model_text(id);
    if (id == 2'd3) return ch;
    if (i < s.len()) return s[i];
    return (i == s.len()) ? 8'h0D : 8'h0A;
  endfunction

`ifdef RESP_GROUP5_EN
  int grp = 0;
`endif

  function automatic int model_push(input logic [1:0] id, input logic [7:0] ch);
    int n;
    n = model_len(id);
    for (int i = 0; i < n; i++) exp_q.push_back(model_byte(id, ch, i));
`ifdef RESP_GROUP5_EN
    if (id == 2'd3) begin
      grp++;
      if (grp == 5) begin
        exp_q.push_back(8'h20);
        n++;
        grp = 0;
      end
    end else begin
      grp = 0;
    end
`endif
    return n;
  endfunction

  // ---------------- compare process ----------------
  always @(posedge clk) begin
    cyc   <= cyc + 1;
    rst_q <= rst_n;
  end

  int         cur_len = 0;
  int         busy_cnt = 0;
  int         accept_cyc = 0;
  bit         lat_pending = 1'b0;
  bit         rx_on = 1'b0;
  int         rx_cnt = 0;
  int         start_len = 0;
  logic [7:0] rx_data = 8'h00;

  always @(negedge clk) begin
    if (!rst_q) begin
      chk("rst_tx", uart_tx, 1'b1);
      chk("rst_busy", busy, 1'b0);
      chk("rst_ready", msg_ready, 1'b0);
    end else begin
      chk("ready_vs_busy", msg_ready, !busy);
      if (!busy) chk("idle_line", uart_tx, 1'b1);
    end

    if (!rst_n || !rst_q) begin
      exp_q.delete();
      busy_cnt    = 0;
      lat_pending = 1'b0;
      rx_on       = 1'b0;
`ifdef RESP_GROUP5_EN
      grp = 0;
`endif
    end else begin
      // busy window length: start latency + N frames + short inter-byte gaps
      if (busy) begin
        busy_cnt++;
      end else if (busy_cnt != 0) begin
        chk("busy_len_ok",
            (busy_cnt > cur_len * FRAME) && (busy_cnt <= cur_len * FRAME + 2 * cur_len), 1'b1);
        busy_cnt = 0;
      end

      // line receiver, sampling mid-bit
      if (!rx_on) begin
        if (uart_tx == 1'b0) begin
          rx_on     = 1'b1;
          rx_cnt    = 0;
          start_len = 1;
          if (lat_pending) begin
            // accept edge, then start bit on the 2nd following edge
            chk("start_latency", cyc - accept_cyc, 3);
            lat_pending = 1'b0;
          end
        end
      end else begin
        rx_cnt++;
        if (rx_cnt <= CPB && uart_tx == 1'b0) start_len++;
        if (rx_cnt % CPB == CPB / 2) begin
          if (rx_cnt / CPB == 0) begin
            chk("start_bit_mid", uart_tx, 1'b0);
          end else if (rx_cnt / CPB <= 8) begin
            rx_data[rx_cnt / CPB - 1] = uart_tx;
          end else begin
            chk("stop_bit", uart_tx, 1'b1);
            rx_log.push_back(rx_data);
            if (exp_q.size() == 0) chk("unexpected_byte", {24'h0, rx_data}, 32'hFFFF_FFFF);
            else chk("rx_byte", rx_data, exp_q.pop_front());
            if (rx_data[0]) chk("start_len", start_len, CPB);
            rx_on = 1'b0;
          end
        end
      end

      if (msg_valid && msg_ready) begin
        cur_len     = model_push(msg_id, msg_char);
        accept_cyc  = cyc;
        lat_pending = 1'b1;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic request(input logic [1:0] id, input logic [7:0] ch);
    int t;
    t = 0;
    msg_valid = 1'b1;
    msg_id    = id;
    msg_char  = ch;
    while (!msg_ready && t < 50) begin
      tick(1);
      t++;
    end
    if (t >= 50) chk("accept_timeout", 1'b0, 1'b1);
    tick(1);
    msg_valid = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int t;
    t = 0;
    while ((busy || !msg_ready) && t < budget) begin
      tick(1);
      t++;
    end
    chk("idle_timeout", t < budget, 1'b1);
    tick(2);
    chk("all_bytes_received", exp_q.size(), 0);
  endtask

  initial begin
    automatic string g1 = "BDZGOAA";
    automatic string g2 = "ABCDE";

    // model pins
    chk("pin_ok_len", model_len(2'd1), 4);
    chk("pin_banner_len", model_len(2'd0), 16);
    chk("pin_banner_b0", model_byte(2'd0, 8'h00, 0), 8'h45);
    chk("pin_banner_b15", model_byte(2'd0, 8'h00, 15), 8'h0A);
    chk("pin_err_b2", model_byte(2'd2, 8'h00, 2), 8'h52);

    // reset
    rst_n = 1'b0;
    tick(5);
    rst_n = 1'b1;
    chk("ready_before_release_edge", msg_ready, 1'b0);
    tick(1);
    chk("ready_after_release", msg_ready, 1'b1);
    chk("busy_after_release", busy, 1'b0);

    // OK
    rx_log.delete();
    request(2'd1, 8'h00);
    wait_idle(6000);
    chk("ok_count", rx_log.size(), 4);
    chk("ok_b0", rx_log[0], 8'h4F);
    chk("ok_b3", rx_log[3], 8'h0A);

    // BANNER then ERR
    rx_log.delete();
    request(2'd0, 8'h00);
    wait_idle(20000);
    chk("banner_count", rx_log.size(), 16);
    chk("banner_b5", rx_log[5], 8'h41);
    rx_log.delete();
    request(2'd2, 8'h00);
    wait_idle(7000);
    chk("err_count", rx_log.size(), 5);
    chk("err_b2", rx_log[2], 8'h52);

    // CHAR with a late char change and an ignored request while busy
    rx_log.delete();
    request(2'd3, 8'h55);
    msg_char = 8'h00;
    tick(3);
    msg_valid = 1'b1;
    msg_id    = 2'd0;
    chk("ready_low_while_busy", msg_ready, 1'b0);
    tick(2);
    msg_valid = 1'b0;
    wait_idle(3000);
    chk("char_count", rx_log.size(), 1);
    chk("char_b0", rx_log[0], 8'h55);

    // reset in the middle of an ERR message
    request(2'd2, 8'h00);
    tick(300);
    rst_n = 1'b0;
    tick(1);
    chk("tx_high_after_reset", uart_tx, 1'b1);
    chk("busy_low_after_reset", busy, 1'b0);
    tick(2);
    rst_n = 1'b1;
    tick(1);
    chk("ready_after_mid_reset", msg_ready, 1'b1);
    rx_log.delete();
    request(2'd1, 8'h00);
    wait_idle(6000);
    chk("ok2_count", rx_log.size(), 4);
    chk("ok2_b0", rx_log[0], 8'h4F);
    chk("ok2_b1", rx_log[1], 8'h4B);
    chk("ok2_b2", rx_log[2], 8'h0D);

    // CHAR grouping
    rx_log.delete();
    for (int i = 0; i < g1.len(); i++) begin
      request(2'd3, g1[i]);
      wait_idle(3000);
    end
`ifdef RESP_GROUP5_EN
    chk("grp_count", rx_log.size(), 8);
    chk("grp_space", rx_log[5], 8'h20);
    chk("grp_after", rx_log[6], 8'h41);
`else
    chk("grp_count", rx_log.size(), 7);
    chk("grp_b5", rx_log[5], 8'h41);
`endif
    request(2'd1, 8'h00);
    wait_idle(6000);
    rx_log.delete();
    for (int i = 0; i < g2.len(); i++) begin
      request(2'd3, g2[i]);
      wait_idle(3000);
    end
`ifdef RESP_GROUP5_EN
    chk("grp2_count", rx_log.size(), 6);
    chk("grp2_last", rx_log[5], 8'h20);
`else
    chk("grp2_count", rx_log.size(), 5);
    chk("grp2_last", rx_log[4], 8'h45);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
